// File: rtl/ram_responder.sv
// ram_responder: single-port word memory behind a request/complete handshake.
// A request (exactly one of Read/Write) is latched in IDLE, held for
// WAIT_STATES extra cycles, performed in ACCESS and retired in DONE.
//
// Handshake: Read/Write are level-sampled only while the FSM is in IDLE;
// Busy is high from the request edge until the DONE edge; Ready pulses for
// exactly one cycle when the access has been performed (Read_data is valid
// from that pulse onwards); Error pulses for one cycle when Read and Write
// are sampled high together in IDLE. Requests outside IDLE are dropped.
module ram_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] Write_data,
  input  logic                  Read,
  input  logic                  Write,
  output logic [DATA_WIDTH-1:0] Read_data,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Error,
  output logic [1:0]            state_dbg
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    op_write_q, op_write_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;

  // Storage is deliberately not reset: Clear must never disturb contents.
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_write_d = op_write_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    busy_d     = busy_q;
    error_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Read ^ Write) begin
          // Snapshot everything so later input changes cannot leak in.
          addr_d     = Address;
          wdata_d    = Write_data;
          op_write_d = Write;
          cnt_d      = WAIT_INIT;
          busy_d     = 1'b1;
          state_d    = S_WAIT;
        end else if (Read && Write) begin
          error_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        // Read_data only moves here, and only for reads.
        if (!op_write_q) begin
          rdata_d = mem[addr_q];
        end
        ready_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; Clear forces the idle, all-zero condition.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  // Memory write on the ACCESS edge; an aborted access never reaches ACCESS.
  always_ff @(posedge Clock) begin
    if (state_q == S_ACCESS && op_write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign Read_data = rdata_q;
  assign Ready     = ready_q;
  assign Busy      = busy_q;
  assign Error     = error_q;
  assign state_dbg = state_q;

endmodule
